// File: rtl/obf_pkg.sv
// Shared definitions for the key-obfuscated channel array: FSM states and
// per-channel mode codes.
package obf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ERROR  = 3'd3,
    ST_ACTIVE = 3'd4
  } obf_state_e;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_INV  = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_ZERO = 2'b11
  } obf_mode_e;

endpackage

// File: rtl/obf_mode_cell.sv
// One obfuscated channel: maps a single data bit through its 2-bit key mode.
module obf_mode_cell
  import obf_pkg::*;
(
  input  logic       din,
  input  logic [1:0] mode,
  output logic       dout
);

  always_comb begin
    dout = 1'b0;
    case (obf_mode_e'(mode))
      MODE_PASS: dout = din;
      MODE_INV:  dout = ~din;
      MODE_ONE:  dout = 1'b1;
      MODE_ZERO: dout = 1'b0;
    endcase
  end

endmodule

// File: rtl/obf_mode_array.sv
// Serially loaded, parity-checked 2-bit-per-channel key that obfuscates NCH
// data channels; a reload from ACTIVE keeps the old key running until commit.
module obf_mode_array
  import obf_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_valid,
  input  logic                         key_bit,
  input  logic                         key_par,
  output logic                         key_ready,
  input  logic                         key_clr,
  input  logic [NCH-1:0]               din,
  input  logic                         din_valid,
  output logic [NCH-1:0]               dout,
  output logic                         dout_valid,
  output logic                         locked,
  output logic                         key_err,
  output logic                         key_ok,
  output obf_state_e                   dbg_state,
  output logic [$clog2(2*NCH+1)-1:0]   dbg_count,
  output logic [2*NCH-1:0]             dbg_shadow
);

  localparam int KEY_W = 2 * NCH;
  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);

  obf_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [KEY_W-1:0] shadow_q, active_key_q;
  logic             par_q, reload_q, key_err_q, key_ok_q;
  logic [NCH-1:0]   dout_q, mapped;
  logic             dout_valid_q;
  logic             ready, accept, parity_ok, flow, last_bit;

  // Key handshake: a bit transfers on a rising edge where key_valid and
  // key_ready are both high; key_clr in the same cycle discards the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACTIVE: ready = 1'b1;
      ST_LOAD:            ready = (cnt_q < CNT_FULL);
      default:            ready = 1'b0;
    endcase
    accept    = key_valid && ready && !key_clr;
    cnt_inc   = cnt_q + CNT_W'(1);
    last_bit  = accept && (state_q == ST_LOAD) && (cnt_inc == CNT_FULL);
    parity_ok = ((^shadow_q) == par_q);
    // Data keeps flowing only under a committed key (ACTIVE, or a reload begun from it).
    flow      = (state_q == ST_ACTIVE) ||
                (((state_q == ST_LOAD) || (state_q == ST_CHECK)) && reload_q);
    if (key_clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACTIVE: if (accept) state_d = ST_LOAD;
        ST_LOAD:            if (last_bit) state_d = ST_CHECK;
        ST_CHECK:           state_d = parity_ok ? ST_ACTIVE : ST_ERROR;
        ST_ERROR:           state_d = ST_ERROR;
        default:            state_d = ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_cell
    obf_mode_cell u_cell (
      .din  (din[i]),
      .mode (active_key_q[2*i+1:2*i]),
      .dout (mapped[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_key_q <= '0;
      par_q        <= 1'b0;
      reload_q     <= 1'b0;
      key_err_q    <= 1'b0;
      key_ok_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (key_clr) begin
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_key_q <= '0;
      par_q        <= 1'b0;
      reload_q     <= 1'b0;
      key_err_q    <= 1'b0;
      key_ok_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      key_ok_q <= 1'b0;
      if (accept) begin
        shadow_q <= {key_bit, shadow_q[KEY_W-1:1]};
        if (state_q == ST_LOAD) begin
          cnt_q <= cnt_inc;
        end else begin
          cnt_q    <= CNT_W'(1);
          reload_q <= (state_q == ST_ACTIVE);
        end
      end
      if (last_bit) par_q <= key_par;
      if (state_q == ST_CHECK) begin
        if (parity_ok) begin
          active_key_q <= shadow_q;
          key_ok_q     <= 1'b1;
          reload_q     <= 1'b0;
        end else begin
          key_err_q    <= 1'b1;
        end
      end
      if (flow) begin
        dout_q       <= mapped;
        dout_valid_q <= din_valid;
      end else begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign key_ready  = ready;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = !flow;
  assign key_err    = key_err_q;
  assign key_ok     = key_ok_q;
  assign dbg_state  = state_q;
  assign dbg_count  = cnt_q;
  assign dbg_shadow = shadow_q;

endmodule

// File: tb/tb_obf_mode_array.sv
// Directed bench for obf_mode_array (NCH=4): expected dout words are queued
// at stimulus time and popped by a negedge monitor whenever dout_valid is high.
module tb_obf_mode_array;
  import obf_pkg::*;

  localparam int NCH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             key_valid = 1'b0, key_bit = 1'b0, key_par = 1'b0, key_clr = 1'b0;
  logic [NCH-1:0]   din = '0;
  logic             din_valid = 1'b0;
  logic             key_ready, dout_valid, locked, key_err, key_ok;
  logic [NCH-1:0]   dout;
  obf_state_e       dbg_state;
  logic [3:0]       dbg_count;
  logic [2*NCH-1:0] dbg_shadow;

  obf_mode_array #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_bit(key_bit),
    .key_par(key_par), .key_ready(key_ready), .key_clr(key_clr), .din(din),
    .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid), .locked(locked),
    .key_err(key_err), .key_ok(key_ok), .dbg_state(dbg_state),
    .dbg_count(dbg_count), .dbg_shadow(dbg_shadow)
  );

  logic [NCH-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Hand-computed mapping under key 8'hE4 (ch0 pass, ch1 invert, ch2 one, ch3 zero).
  logic [NCH-1:0] din_tab[4] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000};
  logic [NCH-1:0] e4_tab[4]  = '{4'b0100, 4'b0111, 4'b0101, 4'b0110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // driver tasks (all start and end 1 time unit after a rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] k, input logic p);
    for (int i = 0; i < 8; i++) begin
      key_valid = 1'b1;
      key_bit   = k[i];
      key_par   = p;
      step();
    end
    key_valid = 1'b0;
  endtask

  task automatic stream(input logic [NCH-1:0] d, input logic [NCH-1:0] e);
    din       = d;
    din_valid = 1'b1;
    exp_q.push_back(e);
    step();
    din_valid = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_dout: got %0h expected no output", dout);
      end else begin
        check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    step();
    step();
    rst_n = 1'b1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_key_ready", 32'(key_ready), 32'd1);
    check("rst_locked", 32'(locked), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_key_err", 32'(key_err), 32'd0);
    check("rst_key_ok", 32'(key_ok), 32'd0);

    // first key E4, good parity
    send_key(8'hE4, 1'b0);
    check("check_state", 32'(dbg_state), 32'(ST_CHECK));
    check("check_key_ready", 32'(key_ready), 32'd0);
    check("check_key_ok", 32'(key_ok), 32'd0);
    key_valid = 1'b1;
    key_bit   = 1'b1;
    step();
    key_valid = 1'b0;
    check("commit_key_ok", 32'(key_ok), 32'd1);
    check("commit_state", 32'(dbg_state), 32'(ST_ACTIVE));
    check("commit_shadow", 32'(dbg_shadow), 32'hE4);
    check("commit_count", 32'(dbg_count), 32'd8);
    check("commit_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 4; i++) stream(din_tab[i], e4_tab[i]);
    check("key_ok_pulse", 32'(key_ok), 32'd0);

    // reload key 00 while streaming: old mapping until commit, then pass-through
    for (int c = 0; c < 9; c++) begin
      key_valid = (c < 8);
      key_bit   = 1'b0;
      key_par   = 1'b0;
      din       = din_tab[c % 4];
      din_valid = 1'b1;
      exp_q.push_back(e4_tab[c % 4]);
      step();
    end
    key_valid = 1'b0;
    din_valid = 1'b0;
    check("reload_key_ok", 32'(key_ok), 32'd1);
    stream(4'b1010, 4'b1010);
    stream(4'b0110, 4'b0110);

    // clear, then clear colliding with a key bit
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    check("clr_state", 32'(dbg_state), 32'(ST_IDLE));
    check("clr_locked", 32'(locked), 32'd1);
    key_clr   = 1'b1;
    key_valid = 1'b1;
    key_bit   = 1'b1;
    step();
    key_clr   = 1'b0;
    key_valid = 1'b0;
    check("clr_win_count", 32'(dbg_count), 32'd0);
    check("clr_win_state", 32'(dbg_state), 32'(ST_IDLE));
    check("clr_win_shadow", 32'(dbg_shadow), 32'd0);

    // bad parity with din offered during a first load: nothing may come out
    din       = 4'b1111;
    din_valid = 1'b1;
    send_key(8'hE4, 1'b1);
    step();
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("err_state", 32'(dbg_state), 32'(ST_ERROR));
    check("err_key_err", 32'(key_err), 32'd1);
    check("err_locked", 32'(locked), 32'd1);
    check("err_key_ready", 32'(key_ready), 32'd0);
    check("err_dout", 32'(dout), 32'd0);
    check("err_shadow", 32'(dbg_shadow), 32'hE4);
    din_valid = 1'b0;
    key_clr   = 1'b1;
    step();
    key_clr   = 1'b0;
    check("err_clr_state", 32'(dbg_state), 32'(ST_IDLE));
    check("err_clr_key_err", 32'(key_err), 32'd0);
    check("err_clr_key_ready", 32'(key_ready), 32'd1);

    // reset after 3 of 8 bits, then a fresh load
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1;
      key_bit   = 1'b1;
      step();
    end
    key_valid = 1'b0;
    check("mid_count", 32'(dbg_count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_count", 32'(dbg_count), 32'd0);
    check("mid_rst_shadow", 32'(dbg_shadow), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_flags", 32'({key_err, key_ok}), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd1);
    step();
    rst_n = 1'b1;
    send_key(8'hE4, 1'b0);
    step();
    check("fresh_key_ok", 32'(key_ok), 32'd1);
    check("fresh_shadow", 32'(dbg_shadow), 32'hE4);
    stream(4'b1010, 4'b0100);
    stream(4'b0101, 4'b0111);

    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
